load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - Memory-stage load/store unit. Takes one load/store request per transaction from the
//   EX/MEM pipeline register and drives the data memory through mem_if (master side).
// - Data memory: ready tied high; write on the request edge; read data registered, so
//   r_data holds mem[addr] in the cycle after the request.
// - Handles byte/half/word sizing, lane selection, load sign/zero extension, misalignment
//   and illegal-funct3 traps. Stalls the pipeline while a load is in flight.
// PARAMETERS
// - REG_RESP    1  1: load result registered (latency 2); 0: combinational from r_data (latency 1)
// - TRAP_MISAL  1  1: misaligned access traps, no memory access; 0: addr[1:0] forced to 0, no trap
// PORTS
// - i_clk           in   1      clock
// - i_rst           in   1      synchronous reset, active-high
// - i_req_valid     in   1      request present
// - o_req_ready     out  1      request accepted this cycle when i_req_valid=1
// - i_req_store     in   1      1=store, 0=load
// - i_funct3        in   3      RV32I funct3: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
// - i_addr          in   32     byte address
// - i_store_data    in   32     rs2 value, LSB-aligned
// - i_rd            in   5      load destination register
// - o_resp_valid    out  1      one-cycle pulse: load result valid
// - o_resp_data     out  32     extended load result
// - o_resp_rd       out  5      rd of completed load
// - o_exc_valid     out  1      one-cycle pulse: trap
// - o_exc_cause     out  2      01 load misaligned, 10 store misaligned, 11 illegal funct3
// - o_exc_addr      out  32     faulting address
// - o_stall         out  1      load in flight
// - if_mem          mst  mem_if  valid, w_en, w_size, addr, w_data -> ; r_data, ready <-
// BEHAVIOUR
// - Reset: state IDLE; o_resp_valid=0, o_exc_valid=0, o_stall=0, if_mem.valid=0; o_resp_data,
//   o_resp_rd, o_exc_cause, o_exc_addr=0. Reset mid-load drops it; no response issued.
// - FSM IDLE -> RD_WAIT -> (RESP if REG_RESP) -> IDLE.
// - o_req_ready = (state==IDLE) && if_mem.ready. Accept = i_req_valid && o_req_ready.
// - IDLE, accepted legal store: if_mem.valid=1, w_en=1, addr=i_addr,
//   w_size WORD/HALF/BYTE from funct3. w_data = i_store_data, unshifted (memory selects lanes).
//   Done in one cycle; no response; stay IDLE.
// - IDLE, accepted legal load: valid=1, w_en=0, addr=i_addr. Register addr, funct3, rd.
//   -> RD_WAIT.
// - RD_WAIT: if_mem.valid=0, addr=registered addr, o_stall=1. Select lane from r_data by
//   addr[1:0] (byte) / addr[1] (half). Sign-extend for 000/001, zero-extend for 100/101.
//   REG_RESP=0: pulse o_resp_valid, -> IDLE. REG_RESP=1: register result, -> RESP.
// - RESP: o_resp_valid=1, o_stall=1 for one cycle; -> IDLE. Next request accepted in IDLE.
// - Misaligned (half addr[0]=1; word addr[1:0]!=0), TRAP_MISAL=1: no memory access.
//   Next cycle: o_exc_valid=1, cause=01/10, o_exc_addr=i_addr. Stay IDLE.
// - Illegal funct3 (load 011/11x; store not 000..010): trap cause 11, no access.
// - Trap takes precedence over access. Only one transaction in flight.
// - if_mem.ready=0 in IDLE holds o_req_ready=0; request left pending.
// TESTING
// - mem[0x10]=0x8899AABB. LB @0x13 (REG_RESP=1): accepted at cycle 0;
//   cycle 2 o_resp_valid=1, data=0xFFFFFF88, rd echoed; o_stall=1 cycles 1-2.
// - Same word, LHU @0x12 -> 0x00008899. LW @0x10 -> 0x8899AABB. REG_RESP=0: result in cycle 1.
// - SB 0x5A @0x11, then LW @0x10 -> 0x88995ABB. SW back-to-back in consecutive cycles:
//   both accepted, o_stall stays 0.
// - LW @0x12 -> no if_mem.valid. Next cycle o_exc_valid=1, cause=01, addr=0x12.
//   SH @0x0B -> cause=10.
// - Load funct3=011 -> cause 11. Request held during RD_WAIT: o_req_ready=0, accepted after.
// - Assert i_rst in RD_WAIT -> no o_resp_valid; next-cycle state IDLE, o_stall=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit.
// Accepts one load/store request per transaction and drives the data memory as its master.
// A load occupies the unit until its result returns. A store completes in the cycle it is accepted.
// Misaligned accesses and illegal funct3 values raise a one-cycle trap pulse.
//
// Ports
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_req_valid / o_req_ready       request handshake
//   i_req_store, i_funct3, i_addr,  request payload: store flag, RV32I funct3, byte address,
//   i_store_data, i_rd              LSB-aligned store data, load destination register
//   o_resp_valid/data/rd            load result pulse, extended data, destination register
//   o_exc_valid/cause/addr          trap pulse; cause 01 load misaligned, 10 store misaligned,
//                                   11 illegal funct3; faulting address
//   o_stall                         a load is in flight
//   mem_valid, mem_w_en, mem_w_size, data memory request: valid, write enable, size
//   mem_addr, mem_w_data            (0 byte, 1 half, 2 word), address, unshifted write data
//   mem_r_data, mem_ready           registered read data (valid the cycle after the request), ready
module load_store_unit #(
    parameter bit REG_RESP   = 1'b1,
    parameter bit TRAP_MISAL = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    input  logic [4:0]  i_rd,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_data,
    output logic [4:0]  o_resp_rd,
    output logic        o_exc_valid,
    output logic [1:0]  o_exc_cause,
    output logic [31:0] o_exc_addr,
    output logic        o_stall,
    output logic        mem_valid,
    output logic        mem_w_en,
    output logic [1:0]  mem_w_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_w_data,
    input  logic [31:0] mem_r_data,
    input  logic        mem_ready
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [1:0] CAUSE_LOAD_MISAL  = 2'b01;
    localparam logic [1:0] CAUSE_STORE_MISAL = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL     = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   addr_q;
    logic [2:0]        funct3_q;
    logic              resp_valid_q;
    logic [XLEN-1:0]   resp_data_q;

    logic              accept_c;
    logic              illegal_c;
    logic              misal_c;
    logic              trap_c;
    logic              access_c;
    logic [1:0]        trap_cause_c;
    logic [XLEN-1:0]   eff_addr_c;
    logic [7:0]        byte_lane_c;
    logic [15:0]       half_lane_c;
    logic [XLEN-1:0]   load_ext_c;

    // Request decode: legality, alignment, trap cause and effective address
    always_comb begin
        accept_c = i_req_valid && o_req_ready;
        if (i_req_store) begin
            illegal_c = i_funct3[2] || (i_funct3[1:0] == 2'b11);
        end else begin
            illegal_c = (i_funct3[1:0] == 2'b11) || (i_funct3[2] && i_funct3[1]);
        end
        misal_c = ((i_funct3[1:0] == SIZE_HALF) && i_addr[0]) ||
                  ((i_funct3[1:0] == SIZE_WORD) && (i_addr[1:0] != 2'b00));
        // An illegal size has no alignment, so the illegal check wins
        trap_c   = illegal_c || (TRAP_MISAL && misal_c);
        access_c = accept_c && !trap_c;
        if (illegal_c) begin
            trap_cause_c = CAUSE_ILLEGAL;
        end else if (i_req_store) begin
            trap_cause_c = CAUSE_STORE_MISAL;
        end else begin
            trap_cause_c = CAUSE_LOAD_MISAL;
        end
        // Without misalignment traps the access is forced onto the containing word
        eff_addr_c = i_addr;
        if (!TRAP_MISAL && misal_c) begin
            eff_addr_c = {i_addr[XLEN-1:2], 2'b00};
        end
    end

    // Memory request: only driven in IDLE; afterwards the address holds the load address
    always_comb begin
        mem_valid  = access_c;
        mem_w_en   = access_c && i_req_store;
        mem_w_size = i_funct3[1:0];
        mem_w_data = i_store_data;
        mem_addr   = (state == IDLE) ? eff_addr_c : addr_q;
    end

    // Lane selection and extension of the returned word
    always_comb begin
        byte_lane_c = mem_r_data[7:0];
        unique case (addr_q[1:0])
            2'd0: byte_lane_c = mem_r_data[7:0];
            2'd1: byte_lane_c = mem_r_data[15:8];
            2'd2: byte_lane_c = mem_r_data[23:16];
            2'd3: byte_lane_c = mem_r_data[31:24];
        endcase
        half_lane_c = addr_q[1] ? mem_r_data[31:16] : mem_r_data[15:0];
        case (funct3_q)
            3'b000:  load_ext_c = {{24{byte_lane_c[7]}}, byte_lane_c};
            3'b001:  load_ext_c = {{16{half_lane_c[15]}}, half_lane_c};
            3'b100:  load_ext_c = {24'd0, byte_lane_c};
            3'b101:  load_ext_c = {16'd0, half_lane_c};
            default: load_ext_c = mem_r_data;
        endcase
    end

    // Transaction FSM with registered trap and response outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            funct3_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            o_resp_rd    <= '0;
            o_exc_valid  <= 1'b0;
            o_exc_cause  <= '0;
            o_exc_addr   <= '0;
        end else begin
            o_exc_valid  <= accept_c && trap_c;
            resp_valid_q <= 1'b0;
            if (accept_c && trap_c) begin
                o_exc_cause <= trap_cause_c;
                o_exc_addr  <= i_addr;
            end
            case (state)
                IDLE: begin
                    if (access_c && !i_req_store) begin
                        addr_q    <= eff_addr_c;
                        funct3_q  <= i_funct3;
                        o_resp_rd <= i_rd;
                        state     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (REG_RESP) begin
                        resp_data_q  <= load_ext_c;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end else begin
                        state <= IDLE;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake and response views of the state
    always_comb begin
        o_req_ready = (state == IDLE) && mem_ready;
        o_stall     = (state != IDLE);
        if (REG_RESP) begin
            o_resp_valid = resp_valid_q;
            o_resp_data  = resp_data_q;
        end else begin
            o_resp_valid = (state == RD_WAIT);
            o_resp_data  = (state == RD_WAIT) ? load_ext_c : '0;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table, hand-written multi-cycle sequences
// and randomized transactions checked against a byte-array reference model.
// dut0 uses default parameters; dut1 uses REG_RESP=0, TRAP_MISAL=0.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mem_clr, mem_ready;
    logic        req_valid, req_valid1, req_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [4:0]  rd;

    logic        req_ready0, resp_valid0, exc_valid0, stall0, m0_valid, m0_w_en;
    logic [31:0] resp_data0, exc_addr0, m0_addr, m0_w_data, m0_r_data;
    logic [4:0]  resp_rd0;
    logic [1:0]  exc_cause0, m0_w_size;

    logic        req_ready1, resp_valid1, exc_valid1, stall1, m1_valid, m1_w_en;
    logic [31:0] resp_data1, exc_addr1, m1_addr, m1_w_data, m1_r_data;
    logic [4:0]  resp_rd1;
    logic [1:0]  exc_cause1, m1_w_size;

    load_store_unit dut0 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready0),
        .i_req_store(req_store), .i_funct3(funct3), .i_addr(addr), .i_store_data(store_data),
        .i_rd(rd), .o_resp_valid(resp_valid0), .o_resp_data(resp_data0), .o_resp_rd(resp_rd0),
        .o_exc_valid(exc_valid0), .o_exc_cause(exc_cause0), .o_exc_addr(exc_addr0),
        .o_stall(stall0), .mem_valid(m0_valid), .mem_w_en(m0_w_en), .mem_w_size(m0_w_size),
        .mem_addr(m0_addr), .mem_w_data(m0_w_data), .mem_r_data(m0_r_data), .mem_ready(mem_ready)
    );

    load_store_unit #(.REG_RESP(1'b0), .TRAP_MISAL(1'b0)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid1), .o_req_ready(req_ready1),
        .i_req_store(req_store), .i_funct3(funct3), .i_addr(addr), .i_store_data(store_data),
        .i_rd(rd), .o_resp_valid(resp_valid1), .o_resp_data(resp_data1), .o_resp_rd(resp_rd1),
        .o_exc_valid(exc_valid1), .o_exc_cause(exc_cause1), .o_exc_addr(exc_addr1),
        .o_stall(stall1), .mem_valid(m1_valid), .mem_w_en(m1_w_en), .mem_w_size(m1_w_size),
        .mem_addr(m1_addr), .mem_w_data(m1_w_data), .mem_r_data(m1_r_data), .mem_ready(mem_ready)
    );

    // Data memories: write on the request edge, registered read data
    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];

    function automatic logic [31:0] mem_merge(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [1:0] lo, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        case (sz)
            2'd0:    r[8*lo +: 8] = wd[7:0];
            2'd1:    r[16*lo[1] +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem0[i] <= '0;
            m0_r_data <= '0;
        end else if (m0_valid && mem_ready) begin
            if (m0_w_en) mem0[m0_addr[7:2]] <= mem_merge(mem0[m0_addr[7:2]], m0_w_size, m0_addr[1:0], m0_w_data);
            else         m0_r_data <= mem0[m0_addr[7:2]];
        end
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem1[i] <= '0;
            m1_r_data <= '0;
        end else if (m1_valid && mem_ready) begin
            if (m1_w_en) mem1[m1_addr[7:2]] <= mem_merge(mem1[m1_addr[7:2]], m1_w_size, m1_addr[1:0], m1_w_data);
            else         m1_r_data <= mem1[m1_addr[7:2]];
        end
    end

    // Reference model: byte-addressed memory plus RV32I load/store rules
    logic [7:0] ref_mem [256];

    function automatic logic [1:0] exp_cause(input logic st, input logic [2:0] f, input logic [31:0] a);
        bit ill;
        ill = st ? (f > 3'd2) : (f == 3'd3 || f == 3'd6 || f == 3'd7);
        if (ill) return 2'd3;
        if ((f[1:0] == 2'd1 && a[0]) || (f[1:0] == 2'd2 && a[1:0] != 2'd0)) return st ? 2'd2 : 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a);
        int n;
        logic [31:0] v;
        n = 1 << f[1:0];
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a[7:0]) + i]) << (8 * i));
        if (!f[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    function automatic void ref_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < (1 << f[1:0]); i++) ref_mem[int'(a[7:0]) + i] = d[8*i +: 8];
    endfunction

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One dut0 transaction starting at a negedge; optionally holds memory ready low first
    task automatic txn(input logic st, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] r, input logic [1:0] ec, input logic [31:0] ed,
                       input bit hold, input string tag);
        int waits;
        req_valid = 1'b1; req_store = st; funct3 = f; addr = a; store_data = d; rd = r;
        if (hold) begin
            mem_ready = 1'b0;
            #1;
            chk({tag, " held ready"}, 32'(req_ready0), 32'd0);
            chk({tag, " held mem valid"}, 32'(m0_valid), 32'd0);
            @(negedge clk);
            mem_ready = 1'b1;
        end
        #1;
        waits = 0;
        while (!req_ready0 && waits < 16) begin
            @(negedge clk); #1; waits++;
        end
        chk({tag, " ready"}, 32'(req_ready0), 32'd1);
        chk({tag, " mem valid"}, 32'(m0_valid), 32'(ec == 2'd0));
        if (ec == 2'd0) begin
            chk({tag, " mem w_en"}, 32'(m0_w_en), 32'(st));
            chk({tag, " mem addr"}, m0_addr, a);
            if (st) ref_store(f, a, d);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk({tag, " exc valid"}, 32'(exc_valid0), 32'(ec != 2'd0));
        if (ec != 2'd0) begin
            chk({tag, " exc cause"}, 32'(exc_cause0), 32'(ec));
            chk({tag, " exc addr"}, exc_addr0, a);
        end
        chk({tag, " resp early"}, 32'(resp_valid0), 32'd0);
        chk({tag, " stall c1"}, 32'(stall0), 32'(ec == 2'd0 && !st));
        if (ec == 2'd0 && !st) begin
            @(negedge clk); #1;
            chk({tag, " resp valid"}, 32'(resp_valid0), 32'd1);
            chk({tag, " resp data"}, resp_data0, ed);
            chk({tag, " resp rd"}, 32'(resp_rd0), 32'(r));
            chk({tag, " stall c2"}, 32'(stall0), 32'd1);
            @(negedge clk); #1;
            chk({tag, " stall end"}, 32'(stall0), 32'd0);
            chk({tag, " resp end"}, 32'(resp_valid0), 32'd0);
        end
    endtask

    // One dut1 load: combinational response in the cycle after acceptance
    task automatic load1(input logic [2:0] f, input logic [31:0] a, input logic [31:0] ea,
                         input logic [4:0] r, input logic [31:0] ed, input string tag);
        req_valid1 = 1'b1; req_store = 1'b0; funct3 = f; addr = a; rd = r;
        #1;
        chk({tag, " ready"}, 32'(req_ready1), 32'd1);
        chk({tag, " mem valid"}, 32'(m1_valid), 32'd1);
        chk({tag, " mem addr"}, m1_addr, ea);
        @(negedge clk);
        req_valid1 = 1'b0;
        #1;
        chk({tag, " resp valid"}, 32'(resp_valid1), 32'd1);
        chk({tag, " resp data"}, resp_data1, ed);
        chk({tag, " resp rd"}, 32'(resp_rd1), 32'(r));
        chk({tag, " no exc"}, 32'(exc_valid1), 32'd0);
        @(negedge clk); #1;
        chk({tag, " resp end"}, 32'(resp_valid1), 32'd0);
        chk({tag, " stall end"}, 32'(stall1), 32'd0);
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] d;
        logic [4:0]  r;
        logic [1:0]  ec;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl [20];

    initial begin
        logic        st;
        logic [2:0]  f;
        logic [31:0] a, d, ed;
        logic [1:0]  ec;

        tbl[0]  = '{1'b1, 3'd2, 32'h10, 32'h8899AABB, 5'd0,  2'd0, 32'h0};
        tbl[1]  = '{1'b0, 3'd0, 32'h13, 32'h0,        5'd5,  2'd0, 32'hFFFFFF88};
        tbl[2]  = '{1'b0, 3'd5, 32'h12, 32'h0,        5'd6,  2'd0, 32'h00008899};
        tbl[3]  = '{1'b0, 3'd2, 32'h10, 32'h0,        5'd7,  2'd0, 32'h8899AABB};
        tbl[4]  = '{1'b0, 3'd1, 32'h10, 32'h0,        5'd8,  2'd0, 32'hFFFFAABB};
        tbl[5]  = '{1'b0, 3'd4, 32'h10, 32'h0,        5'd9,  2'd0, 32'h000000BB};
        tbl[6]  = '{1'b1, 3'd0, 32'h11, 32'hFFFFFF5A, 5'd0,  2'd0, 32'h0};
        tbl[7]  = '{1'b0, 3'd2, 32'h10, 32'h0,        5'd10, 2'd0, 32'h88995ABB};
        tbl[8]  = '{1'b0, 3'd2, 32'h12, 32'h0,        5'd1,  2'd1, 32'h0};
        tbl[9]  = '{1'b1, 3'd1, 32'h0B, 32'h1234,     5'd0,  2'd2, 32'h0};
        tbl[10] = '{1'b0, 3'd3, 32'h10, 32'h0,        5'd2,  2'd3, 32'h0};
        tbl[11] = '{1'b1, 3'd4, 32'h10, 32'h0,        5'd0,  2'd3, 32'h0};
        tbl[12] = '{1'b0, 3'd1, 32'h11, 32'h0,        5'd3,  2'd1, 32'h0};
        tbl[13] = '{1'b1, 3'd2, 32'h11, 32'h0,        5'd0,  2'd2, 32'h0};
        tbl[14] = '{1'b1, 3'd1, 32'h12, 32'h1234C3D4, 5'd0,  2'd0, 32'h0};
        tbl[15] = '{1'b0, 3'd2, 32'h10, 32'h0,        5'd11, 2'd0, 32'hC3D45ABB};
        tbl[16] = '{1'b0, 3'd0, 32'h11, 32'h0,        5'd12, 2'd0, 32'h0000005A};
        tbl[17] = '{1'b1, 3'd2, 32'h14, 32'h0BADF00D, 5'd0,  2'd0, 32'h0};
        tbl[18] = '{1'b0, 3'd1, 32'h16, 32'h0,        5'd13, 2'd0, 32'h00000BAD};
        tbl[19] = '{1'b0, 3'd6, 32'h10, 32'h0,        5'd14, 2'd3, 32'h0};

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        rst = 1'b1; mem_clr = 1'b1; mem_ready = 1'b1;
        req_valid = 1'b0; req_valid1 = 1'b0; req_store = 1'b0;
        funct3 = '0; addr = '0; store_data = '0; rd = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset resp_valid", 32'(resp_valid0), 32'd0);
        chk("reset exc_valid", 32'(exc_valid0), 32'd0);
        chk("reset stall", 32'(stall0), 32'd0);
        chk("reset resp_data", resp_data0, 32'd0);
        chk("reset resp_rd", 32'(resp_rd0), 32'd0);
        chk("reset exc_cause", 32'(exc_cause0), 32'd0);
        chk("reset exc_addr", exc_addr0, 32'd0);
        chk("reset mem valid", 32'(m0_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_clr = 1'b0;

        // Directed vector table
        for (int i = 0; i < 20; i++)
            txn(tbl[i].st, tbl[i].f, tbl[i].a, tbl[i].d, tbl[i].r, tbl[i].ec, tbl[i].ed,
                (i == 3) || (i == 6), $sformatf("vec%0d", i));

        // Back-to-back stores in consecutive cycles
        req_valid = 1'b1; req_store = 1'b1; funct3 = 3'd2; addr = 32'h20; store_data = 32'h11223344;
        #1;
        chk("b2b sw1 ready", 32'(req_ready0), 32'd1);
        chk("b2b sw1 stall", 32'(stall0), 32'd0);
        ref_store(3'd2, 32'h20, 32'h11223344);
        @(negedge clk);
        addr = 32'h24; store_data = 32'h55667788;
        #1;
        chk("b2b sw2 ready", 32'(req_ready0), 32'd1);
        chk("b2b sw2 mem valid", 32'(m0_valid), 32'd1);
        chk("b2b sw2 stall", 32'(stall0), 32'd0);
        ref_store(3'd2, 32'h24, 32'h55667788);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("b2b stall after", 32'(stall0), 32'd0);
        txn(1'b0, 3'd2, 32'h20, 32'h0, 5'd15, 2'd0, 32'h11223344, 1'b0, "b2b lw1");
        txn(1'b0, 3'd2, 32'h24, 32'h0, 5'd16, 2'd0, 32'h55667788, 1'b0, "b2b lw2");

        // Request held pending while a load is in flight
        req_valid = 1'b1; req_store = 1'b0; funct3 = 3'd2; addr = 32'h10; rd = 5'd7;
        #1;
        chk("held first ready", 32'(req_ready0), 32'd1);
        @(negedge clk);
        addr = 32'h14; rd = 5'd8;
        #1;
        chk("held rdwait ready", 32'(req_ready0), 32'd0);
        chk("held rdwait mem valid", 32'(m0_valid), 32'd0);
        chk("held rdwait stall", 32'(stall0), 32'd1);
        @(negedge clk); #1;
        chk("held resp ready", 32'(req_ready0), 32'd0);
        chk("held resp1 valid", 32'(resp_valid0), 32'd1);
        chk("held resp1 data", resp_data0, 32'hC3D45ABB);
        chk("held resp1 rd", 32'(resp_rd0), 32'd7);
        @(negedge clk); #1;
        chk("held second ready", 32'(req_ready0), 32'd1);
        chk("held second mem addr", m0_addr, 32'h14);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("held second stall", 32'(stall0), 32'd1);
        @(negedge clk); #1;
        chk("held resp2 valid", 32'(resp_valid0), 32'd1);
        chk("held resp2 data", resp_data0, 32'h0BADF00D);
        chk("held resp2 rd", 32'(resp_rd0), 32'd8);
        @(negedge clk);

        // Reset during RD_WAIT drops the load
        req_valid = 1'b1; req_store = 1'b0; funct3 = 3'd2; addr = 32'h10; rd = 5'd9;
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        #1;
        chk("rst mid stall before", 32'(stall0), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst mid stall", 32'(stall0), 32'd0);
        chk("rst mid resp", 32'(resp_valid0), 32'd0);
        chk("rst mid ready", 32'(req_ready0), 32'd1);
        @(negedge clk); #1;
        chk("rst mid resp later", 32'(resp_valid0), 32'd0);

        // dut1: unregistered response, misaligned addresses forced onto the word
        req_valid1 = 1'b1; req_store = 1'b1; funct3 = 3'd2; addr = 32'h10; store_data = 32'h8899AABB;
        #1;
        chk("d1 sw ready", 32'(req_ready1), 32'd1);
        @(negedge clk);
        req_valid1 = 1'b0;
        #1;
        load1(3'd2, 32'h10, 32'h10, 5'd3, 32'h8899AABB, "d1 lw");
        load1(3'd2, 32'h12, 32'h10, 5'd4, 32'h8899AABB, "d1 lw misal");
        load1(3'd1, 32'h13, 32'h10, 5'd5, 32'hFFFFAABB, "d1 lh misal");
        req_valid1 = 1'b1; req_store = 1'b1; funct3 = 3'd5; addr = 32'h33;
        #1;
        chk("d1 illegal mem valid", 32'(m1_valid), 32'd0);
        @(negedge clk);
        req_valid1 = 1'b0;
        #1;
        chk("d1 illegal exc", 32'(exc_valid1), 32'd1);
        chk("d1 illegal cause", 32'(exc_cause1), 32'd3);
        chk("d1 illegal addr", exc_addr1, 32'h33);
        @(negedge clk);

        // Randomized transactions against the reference model
        for (int n = 0; n < 250; n++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                f = 3'($urandom_range(0, 7));
            end else begin
                case ($urandom_range(0, 4))
                    0: f = 3'd0;
                    1: f = 3'd1;
                    2: f = 3'd2;
                    3: f = st ? 3'd0 : 3'd4;
                    default: f = st ? 3'd1 : 3'd5;
                endcase
            end
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (f[1:0] == 2'd1) a[0] = 1'b0;
                if (f[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            d  = $urandom;
            ec = exp_cause(st, f, a);
            ed = (ec == 2'd0 && !st) ? ref_load(f, a) : 32'h0;
            txn(st, f, a, d, 5'($urandom_range(0, 31)), ec, ed, ($urandom_range(0, 7) == 0),
                $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
